max11046_frame_capture: RTL and testbench

//  Downstream stage of the MAX11046 control sequencer. Snoops the sequencer's EOC/CS/RD strobes and the ADC's
//  16-bit parallel data bus. Captures one word per RD pulse and tags it with its channel index.

---
 rtl/max11046_pkg.sv | 24 ++
 rtl/max11046_sample_fifo.sv | 58 +++++
 rtl/max11046_frame_capture.sv | 212 +++++++++++++++++++++
 tb/tb_max11046_frame_capture.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max11046_pkg.sv
// Shared definitions for the MAX11046 frame-capture slice.
//   MAX11046_DATA_W  width of the ADC parallel data bus
//   MAX11046_MAX_CH  largest number of channels one conversion frame can hold
//   cap_state_t      capture FSM states (IDLE / ARMED / READ)
//   sample_word_t    one buffered sample: data word, channel index, last-of-frame flag
package max11046_pkg;

  localparam int MAX11046_DATA_W = 16;
  localparam int MAX11046_MAX_CH = 8;
  localparam int MAX11046_CHAN_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_READ  = 2'd2
  } cap_state_t;

  typedef struct packed {
    logic [MAX11046_DATA_W-1:0] data;
    logic [MAX11046_CHAN_W-1:0] chan;
    logic                       last;
  } sample_word_t;

endpackage

// File: rtl/max11046_sample_fifo.sv
// First-word-fall-through synchronous FIFO for captured samples.
// The head entry is presented on pop_data whenever empty is low; pop consumes it.
// Ports:
//   clock1     system clock, rising edge
//   reset      synchronous active-high reset, empties the FIFO
//   push       write push_data (taken when not full, or when full with a pop)
//   push_data  word to store
//   pop        consume the head entry (ignored when empty)
//   pop_data   head entry, meaningful only while empty is low
//   full       DEPTH entries stored
//   empty      no entries stored
// DEPTH must be a power of two, at least 2.
module max11046_sample_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 8
) (
  input  logic         clock1,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the indices match.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         wr_en;
  logic         rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop frees the head slot in the same cycle, so a push into a full FIFO is
  // still accepted; it lands in the slot being vacated.
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock1) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock1) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/max11046_frame_capture.sv
// MAX11046 frame capture: snoops the sequencer's EOC/CS/RD strobes and the ADC
// parallel bus, captures one word per RD pulse, tags it with its channel index and
// streams it out through a FWFT buffer with frame and error flags.
// Ports:
//   clock1        system clock, rising edge
//   reset         synchronous active-high reset
//   eoc_n, cs_n   end-of-conversion / chip select (asynchronous, active low)
//   rd_n          read strobe (asynchronous, active low), db valid while low
//   db            ADC data bus (asynchronous, stable while rd_n low)
//   sample_*      output sample stream (data, channel, last-of-frame, valid)
//   sample_ready  consumer accepts the word when sample_valid & sample_ready
//   frame_done    one-cycle pulse after a complete frame has been captured
//   err_overflow  sticky: a captured word was dropped because the buffer was full
//   err_frame     sticky: frame ended with the wrong read count, or extra read
//   err_clear     clears both sticky flags (a coincident new error wins)
// DATA_W must equal MAX11046_DATA_W; NUM_CH is 1..MAX11046_MAX_CH.
module max11046_frame_capture
  import max11046_pkg::*;
#(
  parameter int NUM_CH      = 6,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock1,
  input  logic              reset,
  input  logic              eoc_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic [DATA_W-1:0] db,
  output logic [DATA_W-1:0] sample_data,
  output logic [2:0]        sample_chan,
  output logic              sample_last,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_frame,
  input  logic              err_clear
);

  localparam int CNT_W  = $clog2(MAX11046_MAX_CH + 1);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam int WORD_W = $bits(sample_word_t);

  localparam logic [CNT_W-1:0]  NUM_CH_C  = CNT_W'(NUM_CH);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_CH - 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] eoc_sync;
  logic [DATA_W-1:0]      db_sync [SYNC_STAGES];
  logic                   rd_hist;
  logic                   cs_hist;
  logic                   eoc_hist;
  logic [DATA_W-1:0]      db_hist;
  logic [WARM_W-1:0]      warm_cnt;

  logic rd_s;
  logic cs_s;
  logic eoc_s;
  logic edges_en;
  logic rd_rise;
  logic cs_rise;
  logic cs_fall;
  logic eoc_fall;

  cap_state_t        state;
  logic [CNT_W-1:0]  chan_cnt;
  logic              capture;
  logic              cap_accept;
  logic              cap_extra;
  logic              frame_end;
  logic              frame_err_evt;
  logic              ovf_evt;

  sample_word_t      push_word_p0;
  logic              vld_p0;

  logic [WORD_W-1:0] fifo_q;
  sample_word_t      out_word;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  // Stage: input synchronizers plus one history flop for edge detection
  always_ff @(posedge clock1) begin
    if (reset) begin
      rd_sync  <= '1;
      cs_sync  <= '1;
      eoc_sync <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) db_sync[i] <= '1;
      rd_hist  <= 1'b1;
      cs_hist  <= 1'b1;
      eoc_hist <= 1'b1;
      db_hist  <= '1;
    end else begin
      rd_sync    <= {rd_sync[SYNC_STAGES-2:0], rd_n};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      eoc_sync   <= {eoc_sync[SYNC_STAGES-2:0], eoc_n};
      db_sync[0] <= db;
      for (int i = 1; i < SYNC_STAGES; i++) db_sync[i] <= db_sync[i-1];
      rd_hist    <= rd_sync[SYNC_STAGES-1];
      cs_hist    <= cs_sync[SYNC_STAGES-1];
      eoc_hist   <= eoc_sync[SYNC_STAGES-1];
      db_hist    <= db_sync[SYNC_STAGES-1];
    end
  end

  // The synchronizers restart at "inactive" after reset. If a pin is already low
  // (reset mid-frame) that would look like a fresh falling edge, so edges are
  // ignored until the chain and history flop have caught up with the pins.
  always_ff @(posedge clock1) begin
    if (reset)                  warm_cnt <= '0;
    else if (warm_cnt != WARM_DONE) warm_cnt <= warm_cnt + WARM_W'(1);
  end

  assign rd_s     = rd_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign eoc_s    = eoc_sync[SYNC_STAGES-1];
  assign edges_en = (warm_cnt == WARM_DONE);
  assign rd_rise  = edges_en && rd_s && !rd_hist;
  assign cs_rise  = edges_en && cs_s && !cs_hist;
  assign cs_fall  = edges_en && !cs_s && cs_hist;
  assign eoc_fall = edges_en && !eoc_s && eoc_hist;

  always_comb begin
    capture       = rd_rise && !cs_s;
    cap_accept    = capture && (state == ST_READ) && (chan_cnt < NUM_CH_C);
    cap_extra     = capture && (state == ST_READ) && (chan_cnt >= NUM_CH_C);
    frame_end     = cs_rise && (state == ST_READ);
    frame_err_evt = cap_extra || (frame_end && (chan_cnt != NUM_CH_C));
    ovf_evt       = vld_p0 && fifo_full && !pop;
  end

  // Stage p0: capture FSM, channel counter, flags and the registered push word
  always_ff @(posedge clock1) begin
    if (reset) begin
      state        <= ST_IDLE;
      chan_cnt     <= '0;
      vld_p0       <= 1'b0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_frame    <= 1'b0;
    end else begin
      vld_p0       <= cap_accept;
      frame_done   <= 1'b0;
      err_overflow <= ovf_evt || (err_overflow && !err_clear);
      err_frame    <= frame_err_evt || (err_frame && !err_clear);
      case (state)
        ST_IDLE: begin
          // A cs_n fall without a preceding EOC still starts a frame.
          if (cs_fall) begin
            state    <= ST_READ;
            chan_cnt <= '0;
          end else if (eoc_fall) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (cs_fall) begin
            state    <= ST_READ;
            chan_cnt <= '0;
          end
        end
        ST_READ: begin
          if (cap_accept) chan_cnt <= chan_cnt + CNT_W'(1);
          if (frame_end) begin
            state      <= ST_IDLE;
            frame_done <= (chan_cnt == NUM_CH_C);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // db_hist is the last bus sample taken while rd_n was still low, so a bus
  // change on the release edge can never leak into the captured word.
  always_ff @(posedge clock1) begin
    if (cap_accept) begin
      push_word_p0.data <= db_hist;
      push_word_p0.chan <= chan_cnt[2:0];
      push_word_p0.last <= (chan_cnt == LAST_IDX);
    end
  end

  // Stage p1: sample buffer
  assign pop = sample_valid && sample_ready;

  max11046_sample_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock1    (clock1),
    .reset     (reset),
    .push      (vld_p0),
    .push_data (push_word_p0),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_word     = fifo_q;
  assign sample_valid = !fifo_empty;
  assign sample_data  = sample_valid ? out_word.data : '0;
  assign sample_chan  = sample_valid ? out_word.chan : '0;
  assign sample_last  = sample_valid && out_word.last;

endmodule

// File: tb/tb_max11046_frame_capture.sv
module tb_max11046_frame_capture;

  logic        clock1 = 1'b0;
  logic        reset = 1'b1;
  logic        eoc_n = 1'b1;
  logic        cs_n = 1'b1;
  logic        rd_n = 1'b1;
  logic [15:0] db = 16'h0000;
  logic [15:0] sample_data;
  logic [2:0]  sample_chan;
  logic        sample_last;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        frame_done;
  logic        err_overflow;
  logic        err_frame;
  logic        err_clear = 1'b0;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [19:0] rx_q [$];

  max11046_frame_capture #(
    .NUM_CH      (6),
    .DATA_W      (16),
    .FIFO_DEPTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clock1       (clock1),
    .reset        (reset),
    .eoc_n        (eoc_n),
    .cs_n         (cs_n),
    .rd_n         (rd_n),
    .db           (db),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .sample_last  (sample_last),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
    .err_frame    (err_frame),
    .err_clear    (err_clear)
  );

  always #5 clock1 = ~clock1;

  // Words accepted by the consumer and frame_done pulses, sampled mid-cycle.
  always @(negedge clock1) begin
    if (sample_valid && sample_ready) rx_q.push_back({sample_data, sample_chan, sample_last});
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock1);
    #1;
  endtask

  task automatic rd_pulse(input logic [15:0] d, input logic flip);
    db = d;
    rd_n = 1'b0;
    tick(4);
    rd_n = 1'b1;
    if (flip) db = 16'hFFFF;
    tick(4);
  endtask

  task automatic frame_start();
    eoc_n = 1'b0;
    tick(3);
    eoc_n = 1'b1;
    tick(3);
    cs_n = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(2);
    cs_n = 1'b1;
    tick(10);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [15:0] d,
                          input logic [2:0] ch, input logic last);
    if (idx < rx_q.size()) begin
      chk($sformatf("%s_data%0d", tag, idx), {16'h0, rx_q[idx][19:4]}, {16'h0, d});
      chk($sformatf("%s_chan%0d", tag, idx), {29'h0, rx_q[idx][3:1]}, {29'h0, ch});
      chk($sformatf("%s_last%0d", tag, idx), {31'h0, rx_q[idx][0]}, {31'h0, last});
    end
  endtask

  initial begin
    int lat;

    // Reset state
    tick(5);
    chk("rst_valid", {31'h0, sample_valid}, 0);
    chk("rst_data", {16'h0, sample_data}, 0);
    chk("rst_chan", {29'h0, sample_chan}, 0);
    chk("rst_last", {31'h0, sample_last}, 0);
    chk("rst_done", {31'h0, frame_done}, 0);
    chk("rst_ovf", {31'h0, err_overflow}, 0);
    chk("rst_ferr", {31'h0, err_frame}, 0);
    reset = 1'b0;
    tick(6);

    // 1: nominal frame, with first-word latency
    sample_ready = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    frame_start();
    db = 16'h1000;
    rd_n = 1'b0;
    tick(4);
    rd_n = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!sample_valid && lat < 12);
    chk("t1_latency", lat, 4);
    tick(2);
    for (int c = 1; c < 6; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
    frame_end();
    chk("t1_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_word("t1", i, 16'h1000 + 16'(i), 3'(i), i == 5);
    chk("t1_done", done_cnt, 1);
    chk("t1_ovf", {31'h0, err_overflow}, 0);
    chk("t1_ferr", {31'h0, err_frame}, 0);

    // 2: backpressure across two frames
    sample_ready = 1'b0;
    rx_q.delete();
    done_cnt = 0;
    for (int f = 0; f < 2; f++) begin
      frame_start();
      for (int c = 0; c < 6; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
      frame_end();
    end
    chk("t2_ovf", {31'h0, err_overflow}, 1);
    chk("t2_ferr", {31'h0, err_frame}, 0);
    chk("t2_done", done_cnt, 2);
    chk("t2_hold_valid", {31'h0, sample_valid}, 1);
    chk("t2_hold_data", {16'h0, sample_data}, 32'h1000);
    sample_ready = 1'b1;
    tick(16);
    chk("t2_count", rx_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_word("t2", i, 16'h1000 + 16'(i % 6), 3'(i % 6), (i % 6) == 5);
    chk("t2_drained", {31'h0, sample_valid}, 0);
    pulse_clear();
    chk("t2_ovf_clr", {31'h0, err_overflow}, 0);

    // 3: short frame
    rx_q.delete();
    done_cnt = 0;
    frame_start();
    for (int c = 0; c < 4; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
    frame_end();
    chk("t3_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) chk_word("t3", i, 16'h1000 + 16'(i), 3'(i), 1'b0);
    chk("t3_ferr", {31'h0, err_frame}, 1);
    chk("t3_done", done_cnt, 0);
    pulse_clear();
    chk("t3_ferr_clr", {31'h0, err_frame}, 0);

    // 4: one read too many
    rx_q.delete();
    frame_start();
    for (int c = 0; c < 7; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
    frame_end();
    chk("t4_count", rx_q.size(), 6);
    chk_word("t4", 5, 16'h1005, 3'd5, 1'b1);
    chk("t4_ferr", {31'h0, err_frame}, 1);
    pulse_clear();

    // 5: bus switches to 0xFFFF on the rd_n release edge
    rx_q.delete();
    done_cnt = 0;
    frame_start();
    for (int c = 0; c < 6; c++) rd_pulse(16'h2000 + 16'(c), 1'b1);
    frame_end();
    db = 16'h0000;
    chk("t5_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_word("t5", i, 16'h2000 + 16'(i), 3'(i), i == 5);
    chk("t5_done", done_cnt, 1);
    chk("t5_ferr", {31'h0, err_frame}, 0);

    // 6: reset after the third read
    sample_ready = 1'b0;
    rx_q.delete();
    frame_start();
    for (int c = 0; c < 3; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
    chk("t6_pre_valid", {31'h0, sample_valid}, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("t6_valid", {31'h0, sample_valid}, 0);
    chk("t6_data", {16'h0, sample_data}, 0);
    chk("t6_chan", {29'h0, sample_chan}, 0);
    chk("t6_ovf", {31'h0, err_overflow}, 0);
    chk("t6_ferr", {31'h0, err_frame}, 0);
    chk("t6_done_out", {31'h0, frame_done}, 0);
    sample_ready = 1'b1;
    rx_q.delete();
    done_cnt = 0;
    for (int c = 3; c < 6; c++) rd_pulse(16'h1000 + 16'(c), 1'b0);
    frame_end();
    chk("t6_ignored", rx_q.size(), 0);
    chk("t6_ignored_ferr", {31'h0, err_frame}, 0);
    chk("t6_ignored_done", done_cnt, 0);
    frame_start();
    for (int c = 0; c < 6; c++) rd_pulse(16'h3000 + 16'(c), 1'b0);
    frame_end();
    chk("t6_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk_word("t6", i, 16'h3000 + 16'(i), 3'(i), i == 5);
    chk("t6_done", done_cnt, 1);
    chk("t6_ferr_end", {31'h0, err_frame}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
